// File: rtl/conv_pkg.sv
// conv_pkg: shared FSM encoding, tile-size helpers and default pipeline delays
// for the convolution tile loader.
package conv_pkg;

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_COMPUTE, S_DRAIN, S_FLUSH} state_e;

   localparam int FP_MUL_DELAY   = 11;
   localparam int FP_ADD_DELAY   = 14;
   localparam int FP_ACCUM_DELAY = 9;

   localparam int K_DEF  = 3;
   localparam int TM_DEF = 16;
   localparam int TN_DEF = 16;
   localparam int TR_DEF = 64;
   localparam int TC_DEF = 16;

   function automatic int in_fm_words(input int tm, input int tr, input int tc);
      return tm * tr * tc;
   endfunction

   function automatic int weight_words(input int tn, input int tm, input int k);
      return tn * tm * k * k;
   endfunction

   localparam int IN_FM_WORDS  = in_fm_words(TM_DEF, TR_DEF, TC_DEF);
   localparam int WEIGHT_WORDS = weight_words(TN_DEF, TM_DEF, K_DEF);

   // Multiply, adder tree, accumulate, kernel window and out_fm write-back.
   localparam int DRAIN_DEF = FP_MUL_DELAY + 2*FP_ADD_DELAY + FP_ACCUM_DELAY
                            + K_DEF*K_DEF - 1 + FP_ADD_DELAY + 3;

endpackage

// File: rtl/stream_buf_writer.sv
// stream_buf_writer: lands one valid/ready stream into a linear buffer write
// port and flags when WORDS words have been written.
module stream_buf_writer #(
   parameter int DW    = 32,
   parameter int AW    = 16,
   parameter int WORDS = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clear,
   input  logic          enable,
   input  logic [DW-1:0] data_i,
   input  logic          valid_i,
   output logic          ready_o,
   output logic [AW-1:0] wr_addr_o,
   output logic [DW-1:0] wr_data_o,
   output logic          wr_ena_o,
   output logic          loaded_o
);

   localparam logic [AW:0] LAST = (AW+1)'(WORDS);

   logic [AW:0]   cnt_q, cnt_d;
   logic [AW-1:0] wr_addr_q;
   logic [DW-1:0] wr_data_q;
   logic          wr_ena_q;
   logic          acc;

   assign ready_o   = enable && (cnt_q < LAST);
   assign acc       = valid_i && ready_o;
   assign cnt_d     = clear ? '0 : cnt_q + (AW+1)'(acc);
   // The counter reaches LAST on the same edge that registers the final write.
   assign loaded_o  = (cnt_q == LAST);
   assign wr_addr_o = wr_addr_q;
   assign wr_data_o = wr_data_q;
   assign wr_ena_o  = wr_ena_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q     <= '0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         wr_ena_q  <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         wr_ena_q <= acc;
         if (acc) begin
            wr_addr_q <= cnt_q[AW-1:0];
            wr_data_q <= data_i;
         end
      end
   end

endmodule

// File: rtl/conv_tile_loader.sv
// conv_tile_loader: loads one in_fm/weight tile, hands it to the convolution
// control path, waits out the pipeline drain and resets the path for the next tile.
module conv_tile_loader
   import conv_pkg::*;
#(
   parameter int AW    = 16,
   parameter int DW    = 32,
   parameter int K     = K_DEF,
   parameter int Tm    = TM_DEF,
   parameter int Tn    = TN_DEF,
   parameter int Tr    = TR_DEF,
   parameter int Tc    = TC_DEF,
   parameter int DRAIN = DRAIN_DEF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          tile_start,
   output logic          busy,
   output logic          tile_done,
   input  logic [DW-1:0] in_fm_data,
   input  logic          in_fm_valid,
   output logic          in_fm_ready,
   input  logic [DW-1:0] weight_data,
   input  logic          weight_valid,
   output logic          weight_ready,
   output logic [AW-1:0] in_fm_wr_addr,
   output logic [DW-1:0] in_fm_wr_data,
   output logic          in_fm_wr_ena,
   output logic [AW-1:0] weight_wr_addr,
   output logic [DW-1:0] weight_wr_data,
   output logic          weight_wr_ena,
   output logic          conv_computing_start,
   input  logic          conv_computing_done,
   output logic          conv_tile_reset
);

   localparam int IFM_WORDS = in_fm_words(Tm, Tr, Tc);
   localparam int WT_WORDS  = weight_words(Tn, Tm, K);
   localparam int DCW       = $clog2(DRAIN + 1);

   if (IFM_WORDS > 2**AW || WT_WORDS > 2**AW) begin : g_size_chk
      $error("conv_tile_loader: tile does not fit in the buffer address space");
   end
   if (DRAIN < 1) begin : g_drain_chk
      $error("conv_tile_loader: DRAIN must be at least 1");
   end

   state_e           state_q, state_d;
   logic [DCW-1:0]   drain_q, drain_d;
   logic             in_loaded, wt_loaded;
   logic             clear, loading;

   assign clear   = (state_q == S_IDLE) && tile_start;
   assign loading = (state_q == S_LOAD);

   stream_buf_writer #(.DW(DW), .AW(AW), .WORDS(IFM_WORDS)) u_in_fm (
      .clk(clk), .rst(rst), .clear(clear), .enable(loading),
      .data_i(in_fm_data), .valid_i(in_fm_valid), .ready_o(in_fm_ready),
      .wr_addr_o(in_fm_wr_addr), .wr_data_o(in_fm_wr_data), .wr_ena_o(in_fm_wr_ena),
      .loaded_o(in_loaded)
   );

   stream_buf_writer #(.DW(DW), .AW(AW), .WORDS(WT_WORDS)) u_weight (
      .clk(clk), .rst(rst), .clear(clear), .enable(loading),
      .data_i(weight_data), .valid_i(weight_valid), .ready_o(weight_ready),
      .wr_addr_o(weight_wr_addr), .wr_data_o(weight_wr_data), .wr_ena_o(weight_wr_ena),
      .loaded_o(wt_loaded)
   );

   always_comb begin
      state_d = state_q;
      drain_d = drain_q;
      case (state_q)
         S_IDLE:    state_d = tile_start ? S_LOAD : S_IDLE;
         S_LOAD:    state_d = (in_loaded && wt_loaded) ? S_COMPUTE : S_LOAD;
         S_COMPUTE: begin
            state_d = conv_computing_done ? S_DRAIN : S_COMPUTE;
            drain_d = conv_computing_done ? DCW'(DRAIN - 1) : drain_q;
         end
         S_DRAIN: begin
            state_d = (drain_q == '0) ? S_FLUSH : S_DRAIN;
            drain_d = drain_q - DCW'(1);
         end
         default:   state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         drain_q <= '0;
      end else begin
         state_q <= state_d;
         drain_q <= drain_d;
      end
   end

   assign busy                 = (state_q != S_IDLE);
   assign conv_computing_start = (state_q == S_COMPUTE);
   assign conv_tile_reset      = (state_q == S_FLUSH);
   assign tile_done            = (state_q == S_FLUSH);

endmodule
